// File: rtl/parking_pkg.sv
// -----------------------------------------------------------------------------
// parking_pkg
//
// Shared constants and helpers for the parking-system timing blocks.
//
// Contents:
//   TIMER_WIDTH       width of the elapsed-time stamp handed to entry/exit logic
//   CLK_FREQ_HZ       nominal system clock frequency
//   TICK_DIV_DEFAULT  prescale used when a target does not override it
//                     (increment every clock)
//   TICK_DIV_1HZ      prescale for one increment per second on the board
//   timestamp_t       type of a sampled timer value
//   elapsed()         modulo-2^TIMER_WIDTH duration between two stamps
//   div_cnt_width()   width of the prescaler counter for a given divide ratio
// -----------------------------------------------------------------------------
package parking_pkg;

  localparam int TIMER_WIDTH      = 10;
  localparam int CLK_FREQ_HZ      = 100_000_000;
  localparam int TICK_DIV_DEFAULT = 1;
  localparam int TICK_DIV_1HZ     = CLK_FREQ_HZ;

  typedef logic [TIMER_WIDTH-1:0] timestamp_t;

  // The counter wraps with no overflow flag, so a duration is always the
  // modular difference of two stamps. Valid as long as a car stays for fewer
  // than 2^TIMER_WIDTH ticks.
  function automatic timestamp_t elapsed(input timestamp_t t_exit,
                                         input timestamp_t t_entry);
    return timestamp_t'(t_exit - t_entry);
  endfunction

  // clog2 of the divide ratio, but never narrower than one bit so the
  // prescaler register always has a legal declaration.
  function automatic int div_cnt_width(input int div);
    return (div > 1) ? $clog2(div) : 1;
  endfunction

endpackage

// File: rtl/timer_tick_gen.sv
// -----------------------------------------------------------------------------
// timer_tick_gen
//
// Timebase prescaler for the parking timer. Produces a one-cycle-wide enable
// that is high on every TICK_DIV-th rising edge after reset release, so the
// k-th tick qualifies the (k*TICK_DIV)-th edge.
//
// Parameters:
//   TICK_DIV  clk cycles per tick, >= 1. 1 means tick on every edge.
//
// Ports:
//   clk    input   1  system clock, rising edge
//   reset  input   1  asynchronous, active-high; clears the prescale phase
//   tick   output  1  count enable for the edge that follows
// -----------------------------------------------------------------------------
module timer_tick_gen
  import parking_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  generate
    if (TICK_DIV <= 1) begin : g_bypass
      // Every edge is a tick edge, so there is no phase to track. Tick is
      // held low while reset is asserted so nothing downstream sees an
      // enable during reset.
      logic w_unused_clk;

      assign w_unused_clk = clk;
      assign tick         = ~reset;
    end else begin : g_div
      localparam int                DIV_W    = div_cnt_width(TICK_DIV);
      localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(TICK_DIV - 1);

      logic [DIV_W-1:0] r_div_cnt;
      logic             w_last;

      // The edge on which the phase counter sits at its last value is the
      // tick edge: the counter wraps and the count register advances on that
      // same edge. After release the phase starts at 0, so the first tick
      // lands on edge TICK_DIV.
      assign w_last = (r_div_cnt == DIV_LAST);

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_div_cnt <= '0;
        end else if (w_last) begin
          r_div_cnt <= '0;
        end else begin
          r_div_cnt <= r_div_cnt + 1'b1;
        end
      end

      // r_div_cnt is 0 throughout reset and DIV_LAST is nonzero here, so
      // tick is already low during reset without further gating.
      assign tick = w_last;
    end
  endgenerate

endmodule

// File: rtl/timer.sv
// -----------------------------------------------------------------------------
// timer
//
// Free-running elapsed-time counter for the parking system. The count
// advances by one on every timebase tick and wraps from 2^COUNT_WIDTH-1 to 0.
// Entry/exit logic samples it and takes modular differences (see
// parking_pkg::elapsed).
//
// Parameters:
//   COUNT_WIDTH  width of timer_count (10 in the parking top level)
//   TICK_DIV     clk cycles per increment, >= 1
//
// Ports:
//   clk          input   1            system clock, rising edge (100 MHz nom.)
//   reset        input   1            asynchronous, active-high
//   timer_count  output  COUNT_WIDTH  current count, straight from a flop
// -----------------------------------------------------------------------------
module timer
  import parking_pkg::*;
#(
  parameter int COUNT_WIDTH = TIMER_WIDTH,
  parameter int TICK_DIV    = TICK_DIV_DEFAULT
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic [COUNT_WIDTH-1:0] timer_count
);

  logic                   w_tick;
  logic [COUNT_WIDTH-1:0] r_count;

  timer_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk   (clk),
    .reset (reset),
    .tick  (w_tick)
  );

  // Plain binary increment: rolling over to 0 is the intended behaviour,
  // there is no saturation and no overflow indication.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (w_tick) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign timer_count = r_count;

endmodule

// File: tb/tb_timer.sv
module tb_timer;

  logic       clk = 1'b0;
  logic       rst1;
  logic       rst4;
  logic [9:0] cnt1;
  logic [9:0] cnt4;

  int errors = 0;
  int checks = 0;

  // Reference model: the number of rising edges since the last reset
  // release; the expected count is floor(edges / div) modulo 1024.
  int m_edges1 = 0;
  int m_edges4 = 0;
  bit mon_en   = 1'b0;

  typedef struct {
    int         edges;
    logic [9:0] exp1;
    logic [9:0] exp4;
  } vec_t;

  vec_t vecs[10];

  always #5 clk = ~clk;

  timer #(.COUNT_WIDTH(10), .TICK_DIV(1)) dut1 (
    .clk         (clk),
    .reset       (rst1),
    .timer_count (cnt1)
  );

  timer #(.COUNT_WIDTH(10), .TICK_DIV(4)) dut4 (
    .clk         (clk),
    .reset       (rst4),
    .timer_count (cnt4)
  );

  function automatic logic [9:0] ref_count(input int edges, input int div);
    return 10'((edges / div) % 1024);
  endfunction

  function automatic void check(input string nm, input logic [9:0] act,
                                input logic [9:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, exp);
    end
  endfunction

  always @(posedge clk or posedge rst1) begin
    if (rst1) m_edges1 <= 0;
    else      m_edges1 <= m_edges1 + 1;
  end

  always @(posedge clk or posedge rst4) begin
    if (rst4) m_edges4 <= 0;
    else      m_edges4 <= m_edges4 + 1;
  end

  // Continuous comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (mon_en) begin
      check("model_div1", cnt1, ref_count(m_edges1, 1));
      check("model_div4", cnt4, ref_count(m_edges4, 4));
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1);
  end

  initial begin
    logic [9:0] v;
    int         run;
    int         hold;
    bit         r1;
    bit         r4;

    vecs[0] = '{1,    10'd1,    10'd0};
    vecs[1] = '{2,    10'd2,    10'd0};
    vecs[2] = '{3,    10'd3,    10'd0};
    vecs[3] = '{4,    10'd4,    10'd1};
    vecs[4] = '{7,    10'd7,    10'd1};
    vecs[5] = '{8,    10'd8,    10'd2};
    vecs[6] = '{100,  10'd100,  10'd25};
    vecs[7] = '{1023, 10'd1023, 10'd255};
    vecs[8] = '{1024, 10'd0,    10'd256};
    vecs[9] = '{1025, 10'd1,    10'd256};

    // Absolute-time sequence: reset held 0..20 ns, edges at 5, 15, 25 ...
    rst1 = 1'b1;
    rst4 = 1'b1;
    #1;  mon_en = 1'b1;
    #10; check("reset_hold_11ns", cnt1, 10'd0);
         check("reset_hold_11ns_div4", cnt4, 10'd0);
    #5;  check("reset_hold_16ns", cnt1, 10'd0);
    #4;  rst1 = 1'b0; rst4 = 1'b0;                 // t = 20
    #6;  check("first_edge_25ns", cnt1, 10'd1);    // t = 26
         check("first_edge_25ns_div4", cnt4, 10'd0);
    #10; check("second_edge_35ns", cnt1, 10'd2);   // t = 36
    #980; check("edge_1015ns", cnt1, 10'd100);     // t = 1016
          check("edge_1015ns_div4", cnt4, 10'd25);
    #4;  rst1 = 1'b1; rst4 = 1'b1;                 // t = 1020
    #1;  check("midrun_async_clear", cnt1, 10'd0);
         check("midrun_async_clear_div4", cnt4, 10'd0);
    #19; check("midrun_hold_1040ns", cnt1, 10'd0); // t = 1040
    rst1 = 1'b0; rst4 = 1'b0;
    #6;  check("restart_1045ns", cnt1, 10'd1);     // t = 1046
    #990; check("restart_2035ns", cnt1, 10'd100);  // t = 2036
          check("restart_2035ns_div4", cnt4, 10'd25);

    // Table: reset both, release between edges, run N edges, compare.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #2;
      rst1 = 1'b1; rst4 = 1'b1;
      #1;
      check("vec_async_clear", cnt1, 10'd0);
      check("vec_async_clear_div4", cnt4, 10'd0);
      @(negedge clk); #2;
      rst1 = 1'b0; rst4 = 1'b0;
      repeat (vecs[i].edges) @(posedge clk);
      #1;
      check($sformatf("vec%0d_div1_edges%0d", i, vecs[i].edges), cnt1, vecs[i].exp1);
      check($sformatf("vec%0d_div4_edges%0d", i, vecs[i].edges), cnt4, vecs[i].exp4);
    end

    // Reset at prescaler phase 2 must restart the full period.
    @(negedge clk); #2; rst4 = 1'b1;
    @(negedge clk); #2; rst4 = 1'b0;
    repeat (2) @(posedge clk);
    #1; check("phase2_before_reset", cnt4, 10'd0);
    @(negedge clk); #2; rst4 = 1'b1;
    @(negedge clk); #2; rst4 = 1'b0;
    for (int e = 1; e <= 4; e++) begin
      @(posedge clk); #1;
      check($sformatf("phase_restart_edge%0d", e), cnt4, (e == 4) ? 10'd1 : 10'd0);
    end

    // Stability on the three non-tick edges of each period, sampled twice
    // per cycle.
    v = 10'd1;
    for (int p = 0; p < 3; p++) begin
      for (int e = 1; e <= 3; e++) begin
        @(posedge clk); #1;
        check("hold_after_edge", cnt4, v);
        #3;
        check("hold_mid_cycle", cnt4, v);
      end
      @(posedge clk); #1;
      v = v + 10'd1;
      check("tick_edge_increment", cnt4, v);
    end

    // Randomised reset pulses and run lengths against the model.
    for (int it = 0; it < 40; it++) begin
      run  = $urandom_range(1, 300);
      hold = $urandom_range(0, 3);
      r1   = 1'($urandom_range(0, 1));
      r4   = 1'($urandom_range(0, 1));
      if (!r1 && !r4) r1 = 1'b1;
      repeat (run) @(posedge clk);
      @(negedge clk);
      #($urandom_range(1, 3));
      if (r1) rst1 = 1'b1;
      if (r4) rst4 = 1'b1;
      #1;
      if (r1) check("rand_async_clear_div1", cnt1, 10'd0);
      if (r4) check("rand_async_clear_div4", cnt4, 10'd0);
      repeat (hold) @(posedge clk);
      @(negedge clk); #2;
      rst1 = 1'b0;
      rst4 = 1'b0;
    end
    repeat (20) @(posedge clk);
    @(negedge clk); #1;

    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
